csr_file: RTL and testbench

- Machine-mode CSR register file for the RV32I core. It is the responder for the CSR packet emitted by instruction decode.
- Executes CSRRW/RS/RC and their immediate forms against architectural CSRs.
- Owns trap entry and MRET state, and runs the cycle and instret counters.
- Sits in the execute stage. The trap unit drives trap/mret strobes, and the commit stage drives retire.

---
 rtl/csr_file.sv | 177 +++++++++++++++++
 tb/tb_csr_file.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// Machine-mode CSR register file for the RV32I core: CSR read/modify/write,
// trap entry and MRET state, and the 64-bit cycle/instret counters.
module csr_file #(
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_valid,
  input  logic [2:0]  csr_mode,
  input  logic        csr_use_imm,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  src_idx,
  input  logic [31:0] rs1_data,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_tval,
  input  logic        mret_valid,
  input  logic        retire_valid,
  output logic [31:0] trap_vector,
  output logic [31:0] mepc_out,
  output logic        mie_out
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  localparam logic [31:0] MTVEC_RESET = {RESET_MTVEC[31:2], 2'b00};

  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  logic        supported;
  logic [31:0] read_val;
  logic [31:0] mstatus_val;
  logic        write_intent;
  logic        csr_we;
  logic [31:0] operand;
  logic [31:0] wdata;

  assign mstatus_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};

  always_comb begin
    supported = 1'b1;
    read_val  = 32'h0;
    case (csr_addr)
      ADDR_MSTATUS:                  read_val = mstatus_val;
      ADDR_MISA:                     read_val = MISA_VALUE;
      ADDR_MTVEC:                    read_val = mtvec_q;
      ADDR_MSCRATCH:                 read_val = mscratch_q;
      ADDR_MEPC:                     read_val = mepc_q;
      ADDR_MCAUSE:                   read_val = mcause_q;
      ADDR_MTVAL:                    read_val = mtval_q;
      ADDR_MCYCLE, ADDR_CYCLE:       read_val = mcycle_q[31:0];
      ADDR_MCYCLEH, ADDR_CYCLEH:     read_val = mcycle_q[63:32];
      ADDR_MINSTRET, ADDR_INSTRET:   read_val = minstret_q[31:0];
      ADDR_MINSTRETH, ADDR_INSTRETH: read_val = minstret_q[63:32];
      ADDR_MHARTID:                  read_val = HART_ID;
      default:                       supported = 1'b0;
    endcase
  end

  // Set/clear with a zero rs1 field is a pure read, which keeps read-only CSRs legal.
  always_comb begin
    write_intent = (csr_mode[1:0] == 2'b01) ||
                   ((csr_mode[1:0] != 2'b00) && (src_idx != 5'd0));
    csr_illegal  = csr_valid &&
                   (!supported || ((csr_addr[11:10] == 2'b11) && write_intent));
    csr_we       = csr_valid && !csr_illegal && write_intent;
    csr_rdata    = read_val;
    operand      = csr_use_imm ? {27'b0, src_idx} : rs1_data;
    case (csr_mode[1:0])
      2'b10:   wdata = read_val | operand;
      2'b11:   wdata = read_val & ~operand;
      default: wdata = operand;
    endcase
  end

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'b0, retire_valid};

    if (csr_we) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          mie_d  = wdata[3];
          mpie_d = wdata[7];
        end
        ADDR_MTVEC:     mtvec_d    = {wdata[31:2], 2'b00};
        ADDR_MSCRATCH:  mscratch_d = wdata;
        ADDR_MEPC:      mepc_d     = {wdata[31:2], 2'b00};
        ADDR_MCAUSE:    mcause_d   = wdata;
        ADDR_MTVAL:     mtval_d    = wdata;
        ADDR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wdata};
        ADDR_MCYCLEH:   mcycle_d   = {wdata, mcycle_q[31:0]};
        ADDR_MINSTRET:  minstret_d = {minstret_q[63:32], wdata};
        ADDR_MINSTRETH: minstret_d = {wdata, minstret_q[31:0]};
        default: ;
      endcase
    end

    // Later assignments win: trap overrides mret, which overrides a CSR write.
    if (mret_valid) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end

    if (trap_valid) begin
      mepc_d   = {trap_pc[31:2], 2'b00};
      mcause_d = trap_cause;
      mtval_d  = trap_tval;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mtval_q    <= 32'h0;
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign trap_vector = mtvec_q;
  assign mepc_out    = mepc_q;
  assign mie_out     = mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed testbench for csr_file: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_csr_file;

  logic        clk;
  logic        rst;
  logic        csr_valid;
  logic [2:0]  csr_mode;
  logic        csr_use_imm;
  logic [11:0] csr_addr;
  logic [4:0]  src_idx;
  logic [31:0] rs1_data;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic [31:0] trap_tval;
  logic        mret_valid;
  logic        retire_valid;
  logic [31:0] trap_vector;
  logic [31:0] mepc_out;
  logic        mie_out;

  int checks;
  int passed;

  csr_file dut (
    .clk          (clk),
    .rst          (rst),
    .csr_valid    (csr_valid),
    .csr_mode     (csr_mode),
    .csr_use_imm  (csr_use_imm),
    .csr_addr     (csr_addr),
    .src_idx      (src_idx),
    .rs1_data     (rs1_data),
    .csr_rdata    (csr_rdata),
    .csr_illegal  (csr_illegal),
    .trap_valid   (trap_valid),
    .trap_pc      (trap_pc),
    .trap_cause   (trap_cause),
    .trap_tval    (trap_tval),
    .mret_valid   (mret_valid),
    .retire_valid (retire_valid),
    .trap_vector  (trap_vector),
    .mepc_out     (mepc_out),
    .mie_out      (mie_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; strobes last exactly one cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    csr_valid    = 1'b0;
    trap_valid   = 1'b0;
    mret_valid   = 1'b0;
    retire_valid = 1'b0;
    #1;
  endtask

  task automatic csr_op(input logic [2:0] mode, input logic imm, input logic [11:0] addr,
                        input logic [4:0] idx, input logic [31:0] data);
    csr_valid   = 1'b1;
    csr_mode    = mode;
    csr_use_imm = imm;
    csr_addr    = addr;
    src_idx     = idx;
    rs1_data    = data;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (trap_vector !== 32'h0) $display("[TB] FAIL reset_trap_vector actual=%h expected=%h", trap_vector, 32'h0);
    else passed++;
    checks++;
    if (mepc_out !== 32'h0) $display("[TB] FAIL reset_mepc actual=%h expected=%h", mepc_out, 32'h0);
    else passed++;
    checks++;
    if (mie_out !== 1'b0) $display("[TB] FAIL reset_mie actual=%b expected=%b", mie_out, 1'b0);
    else passed++;
    csr_op(3'b010, 1'b0, 12'hC00, 5'd0, 32'h0);
    checks++;
    if (csr_rdata !== 32'h0) $display("[TB] FAIL reset_mcycle actual=%h expected=%h", csr_rdata, 32'h0);
    else passed++;
    tick();
    csr_op(3'b010, 1'b0, 12'hF14, 5'd0, 32'h0);
    checks++;
    if (csr_rdata !== 32'h0 || csr_illegal !== 1'b0)
      $display("[TB] FAIL mhartid_read actual=%h/%b expected=%h/%b", csr_rdata, csr_illegal, 32'h0, 1'b0);
    else passed++;
    tick();
    csr_op(3'b010, 1'b0, 12'h301, 5'd0, 32'h0);
    checks++;
    if (csr_rdata !== 32'h4000_0100) $display("[TB] FAIL misa_read actual=%h expected=%h", csr_rdata, 32'h4000_0100);
    else passed++;
    tick();
  endtask

  task automatic test_mtvec_write();
    csr_op(3'b001, 1'b0, 12'h305, 5'd1, 32'h8000_0103);
    checks++;
    if (csr_rdata !== 32'h0) $display("[TB] FAIL mtvec_old actual=%h expected=%h", csr_rdata, 32'h0);
    else passed++;
    tick();
    checks++;
    if (trap_vector !== 32'h8000_0100) $display("[TB] FAIL mtvec_vector actual=%h expected=%h", trap_vector, 32'h8000_0100);
    else passed++;
  endtask

  task automatic test_trap_mret();
    csr_op(3'b110, 1'b1, 12'h300, 5'd8, 32'h0);
    tick();
    checks++;
    if (mie_out !== 1'b1) $display("[TB] FAIL csrrsi_mie actual=%b expected=%b", mie_out, 1'b1);
    else passed++;
    trap_valid = 1'b1;
    trap_pc    = 32'h0000_0046;
    trap_cause = 32'd2;
    trap_tval  = 32'h0000_DEAD;
    tick();
    checks++;
    if (mepc_out !== 32'h44 || mie_out !== 1'b0)
      $display("[TB] FAIL trap_entry actual=%h/%b expected=%h/%b", mepc_out, mie_out, 32'h44, 1'b0);
    else passed++;
    csr_op(3'b010, 1'b0, 12'h300, 5'd0, 32'h0);
    checks++;
    if (csr_rdata !== 32'h0000_1880) $display("[TB] FAIL trap_mstatus actual=%h expected=%h", csr_rdata, 32'h0000_1880);
    else passed++;
    tick();
    csr_op(3'b010, 1'b0, 12'h342, 5'd0, 32'h0);
    checks++;
    if (csr_rdata !== 32'd2) $display("[TB] FAIL trap_mcause actual=%h expected=%h", csr_rdata, 32'd2);
    else passed++;
    tick();
    csr_op(3'b010, 1'b0, 12'h343, 5'd0, 32'h0);
    checks++;
    if (csr_rdata !== 32'h0000_DEAD) $display("[TB] FAIL trap_mtval actual=%h expected=%h", csr_rdata, 32'h0000_DEAD);
    else passed++;
    tick();
    mret_valid = 1'b1;
    tick();
    checks++;
    if (mie_out !== 1'b1) $display("[TB] FAIL mret_mie actual=%b expected=%b", mie_out, 1'b1);
    else passed++;
    csr_op(3'b010, 1'b0, 12'h300, 5'd0, 32'h0);
    checks++;
    if (csr_rdata !== 32'h0000_1888) $display("[TB] FAIL mret_mstatus actual=%h expected=%h", csr_rdata, 32'h0000_1888);
    else passed++;
    tick();
  endtask

  task automatic test_cycle_counter();
    do_reset();
    repeat (10) tick();
    csr_op(3'b010, 1'b0, 12'hC00, 5'd0, 32'h0);
    checks++;
    if (csr_rdata !== 32'd10 || csr_illegal !== 1'b0)
      $display("[TB] FAIL cycle_read actual=%0d/%b expected=%0d/%b", csr_rdata, csr_illegal, 10, 1'b0);
    else passed++;
    tick();
    csr_op(3'b001, 1'b0, 12'hC00, 5'd5, 32'h1234_5678);
    checks++;
    if (csr_illegal !== 1'b1) $display("[TB] FAIL cycle_ro_write actual=%b expected=%b", csr_illegal, 1'b1);
    else passed++;
    tick();
    csr_op(3'b010, 1'b0, 12'hB00, 5'd0, 32'h0);
    checks++;
    if (csr_rdata !== 32'd12) $display("[TB] FAIL cycle_unchanged actual=%0d expected=%0d", csr_rdata, 12);
    else passed++;
    tick();
  endtask

  task automatic test_instret();
    csr_op(3'b001, 1'b0, 12'hB02, 5'd3, 32'hFFFF_FFFF);
    retire_valid = 1'b1;
    tick();
    csr_op(3'b010, 1'b0, 12'hB02, 5'd0, 32'h0);
    checks++;
    if (csr_rdata !== 32'hFFFF_FFFF) $display("[TB] FAIL instret_low_write actual=%h expected=%h", csr_rdata, 32'hFFFF_FFFF);
    else passed++;
    tick();
    csr_op(3'b010, 1'b0, 12'hB82, 5'd0, 32'h0);
    checks++;
    if (csr_rdata !== 32'h0) $display("[TB] FAIL instret_high_hold actual=%h expected=%h", csr_rdata, 32'h0);
    else passed++;
    tick();
    retire_valid = 1'b1;
    tick();
    csr_op(3'b010, 1'b0, 12'hC02, 5'd0, 32'h0);
    checks++;
    if (csr_rdata !== 32'h0) $display("[TB] FAIL instret_carry_low actual=%h expected=%h", csr_rdata, 32'h0);
    else passed++;
    tick();
    csr_op(3'b010, 1'b0, 12'hC82, 5'd0, 32'h0);
    checks++;
    if (csr_rdata !== 32'h1) $display("[TB] FAIL instret_carry_high actual=%h expected=%h", csr_rdata, 32'h1);
    else passed++;
    tick();
  endtask

  task automatic test_set_clear();
    csr_op(3'b001, 1'b0, 12'h340, 5'd2, 32'h0000_F0F0);
    tick();
    csr_op(3'b011, 1'b0, 12'h340, 5'd2, 32'h0000_00F0);
    checks++;
    if (csr_rdata !== 32'h0000_F0F0) $display("[TB] FAIL mscratch_old actual=%h expected=%h", csr_rdata, 32'h0000_F0F0);
    else passed++;
    tick();
    csr_op(3'b110, 1'b1, 12'h340, 5'd5, 32'h0);
    checks++;
    if (csr_rdata !== 32'h0000_F000) $display("[TB] FAIL mscratch_rc actual=%h expected=%h", csr_rdata, 32'h0000_F000);
    else passed++;
    tick();
    csr_op(3'b111, 1'b1, 12'h340, 5'd0, 32'h0);
    checks++;
    if (csr_rdata !== 32'h0000_F005) $display("[TB] FAIL mscratch_rsi actual=%h expected=%h", csr_rdata, 32'h0000_F005);
    else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    csr_op(3'b001, 1'b0, 12'h341, 5'd4, 32'h0000_1234);
    trap_valid = 1'b1;
    trap_pc    = 32'h0000_0100;
    trap_cause = 32'd11;
    trap_tval  = 32'h0;
    tick();
    checks++;
    if (mepc_out !== 32'h0000_0100) $display("[TB] FAIL trap_over_write actual=%h expected=%h", mepc_out, 32'h0000_0100);
    else passed++;
    csr_op(3'b001, 1'b0, 12'h7C0, 5'd1, 32'hAAAA_AAAA);
    checks++;
    if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0)
      $display("[TB] FAIL unsupported_addr actual=%b/%h expected=%b/%h", csr_illegal, csr_rdata, 1'b1, 32'h0);
    else passed++;
    tick();
    csr_op(3'b001, 1'b0, 12'h340, 5'd1, 32'h5555_0000);
    mret_valid = 1'b1;
    tick();
    csr_op(3'b010, 1'b0, 12'h340, 5'd0, 32'h0);
    checks++;
    if (csr_rdata !== 32'h5555_0000) $display("[TB] FAIL unrelated_write actual=%h expected=%h", csr_rdata, 32'h5555_0000);
    else passed++;
    tick();
  endtask

  task automatic test_mid_reset();
    csr_op(3'b110, 1'b1, 12'h300, 5'd8, 32'h0);
    tick();
    trap_valid = 1'b1;
    trap_pc    = 32'h0000_0200;
    trap_cause = 32'd7;
    trap_tval  = 32'h0000_0077;
    rst        = 1'b1;
    @(posedge clk);
    #1;
    trap_valid = 1'b0;
    rst        = 1'b0;
    #1;
    csr_op(3'b010, 1'b0, 12'hB00, 5'd0, 32'h0);
    checks++;
    if (csr_rdata !== 32'h0) $display("[TB] FAIL mid_reset_mcycle actual=%h expected=%h", csr_rdata, 32'h0);
    else passed++;
    checks++;
    if (trap_vector !== 32'h0 || mepc_out !== 32'h0 || mie_out !== 1'b0)
      $display("[TB] FAIL mid_reset_outputs actual=%h/%h/%b expected=%h/%h/%b",
               trap_vector, mepc_out, mie_out, 32'h0, 32'h0, 1'b0);
    else passed++;
    tick();
    csr_op(3'b010, 1'b0, 12'h340, 5'd0, 32'h0);
    checks++;
    if (csr_rdata !== 32'h0) $display("[TB] FAIL mid_reset_mscratch actual=%h expected=%h", csr_rdata, 32'h0);
    else passed++;
    tick();
    csr_op(3'b010, 1'b0, 12'h342, 5'd0, 32'h0);
    checks++;
    if (csr_rdata !== 32'h0) $display("[TB] FAIL mid_reset_mcause actual=%h expected=%h", csr_rdata, 32'h0);
    else passed++;
    tick();
    csr_op(3'b010, 1'b0, 12'h300, 5'd0, 32'h0);
    checks++;
    if (csr_rdata !== 32'h0000_1800) $display("[TB] FAIL mid_reset_mstatus actual=%h expected=%h", csr_rdata, 32'h0000_1800);
    else passed++;
    tick();
  endtask

  initial begin
    checks       = 0;
    passed       = 0;
    rst          = 1'b1;
    csr_valid    = 1'b0;
    csr_mode     = 3'b000;
    csr_use_imm  = 1'b0;
    csr_addr     = 12'h0;
    src_idx      = 5'd0;
    rs1_data     = 32'h0;
    trap_valid   = 1'b0;
    trap_pc      = 32'h0;
    trap_cause   = 32'h0;
    trap_tval    = 32'h0;
    mret_valid   = 1'b0;
    retire_valid = 1'b0;

    test_reset();
    test_mtvec_write();
    test_trap_mret();
    test_cycle_counter();
    test_instret();
    test_set_clear();
    test_back_to_back();
    test_mid_reset();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
